// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared definitions for the elastic pipeline-stage register:
//   - pipe_state_e : stage occupancy codes (EMPTY / BUSY / FULL)
//   - PIPE_CNT_W   : default width of the optional performance counters
//   - st_valid()   : true when the main entry holds a beat
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    localparam int PIPE_CNT_W = 16;

    // EMPTY: no entry valid; BUSY: main only; FULL: main and skid.
    typedef enum logic [1:0] {
        PIPE_ST_EMPTY = 2'b00,
        PIPE_ST_BUSY  = 2'b01,
        PIPE_ST_FULL  = 2'b10
    } pipe_state_e;

    // The main entry is valid in every state except EMPTY.
    function automatic logic st_valid(input pipe_state_e st);
        return st != PIPE_ST_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_sat_counter
// Saturating up-counter used for the stage performance counters. It counts
// one per cycle while inc is high, sticks at all-ones, and is cleared only by
// reset.
// Ports:
//   clk   in   clock, rising edge
//   reset in   asynchronous, active-high
//   inc   in   count enable for this cycle
//   cnt   out  W-bit count value
// -----------------------------------------------------------------------------
module pipe_skid_reg_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline-stage register with a 2-entry skid buffer. The upstream
// ready is a flop, so no combinational ready path crosses stages, yet the
// stage still sustains one beat per cycle when downstream keeps out_ready=1.
// Beats are delivered in strict FIFO order and never modified.
//
// Parameters:
//   WIDTH     payload width in bits
//   RESET_VAL data register value after reset/flush; out_data while idle
//   CNT_W     performance counter width
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   flush      in   synchronous kill of the stage contents (top priority)
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat (registered)
//   in_data    in   upstream payload
//   out_valid  out  downstream beat valid
//   out_ready  in   downstream accepts
//   out_data   out  downstream payload (RESET_VAL when out_valid=0)
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0
//   flush_cnt  out  flushes that discarded at least one beat
//
// Build option: define PIPE_SKID_PERF_EN to instantiate the two saturating
// performance counters; otherwise stall_cnt and flush_cnt are tied to 0.
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             main_v;
    logic             in_fire;
    logic             out_fire;

    assign main_v   = st_valid(state_q);
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_v & out_ready;

    always_comb begin
        // NOTE: every target gets a default before any branch; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush wins over any handshake: a beat offered this cycle is
            // dropped even though in_ready is high.
            state_d = PIPE_ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                PIPE_ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = PIPE_ST_BUSY;
                        main_d  = in_data;
                    end
                end
                PIPE_ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d = PIPE_ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = PIPE_ST_EMPTY;
                    end
                end
                PIPE_ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = PIPE_ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = PIPE_ST_EMPTY;
                end
            endcase
        end
    end

    // NOTE: the data registers are reset as well as the control, so a
    // freshly reset or flushed stage holds RESET_VAL rather than stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PIPE_ST_EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational block.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != PIPE_ST_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign out_data  = main_v ? main_q : RESET_VAL;

`ifdef PIPE_SKID_PERF_EN
    pipe_skid_reg_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_v & ~out_ready),
        .cnt   (stall_cnt)
    );

    // Only flushes that actually killed a beat are counted.
    pipe_skid_reg_sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & main_v),
        .cnt   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg. The reference is a plain FIFO queue
// of accepted beats with capacity 2: out_valid means "queue not empty",
// in_ready means "fewer than 2 beats held", out_data is the queue head.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge and the model books accepted beats just after it.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int             W  = 32;
    localparam logic [W-1:0]   RV = 32'hDEAD_BEEF;
    localparam int             CW = 4;
    localparam int             CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [W-1:0] exp_q[$];
    bit           mon_en       = 1'b0;
    bit           exp_ready    = 1'b1;
    bit           exp_nonempty = 1'b0;
    int           exp_stall    = 0;
    int           exp_flush    = 0;
    int           sz;
    logic [W-1:0] head;
    bit           prev_stalled = 1'b0;
    logic [W-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs with the model, pop on delivery.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            sz   = exp_q.size();
            head = (sz > 0) ? exp_q[0] : RV;
            check("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
            check("in_ready",  {63'd0, in_ready},  {63'd0, sz < 2});
            check("out_data",  {32'd0, out_data},  {32'd0, head});
            if (prev_stalled) begin
                check("stable_valid", {63'd0, out_valid}, 64'd1);
                check("stable_data",  {32'd0, out_data},  {32'd0, prev_data});
            end
`ifdef PIPE_SKID_PERF_EN
            check("stall_cnt", {60'd0, stall_cnt}, 64'(exp_stall));
            check("flush_cnt", {60'd0, flush_cnt}, 64'(exp_flush));
`else
            check("stall_cnt", {60'd0, stall_cnt}, 64'd0);
            check("flush_cnt", {60'd0, flush_cnt}, 64'd0);
`endif
            // Bookkeeping for the coming rising edge.
            exp_ready    = (sz < 2);
            exp_nonempty = (sz > 0);
            prev_stalled = (sz > 0) && !out_ready && !flush;
            prev_data    = head;
            if (sz > 0 && !out_ready && exp_stall < CNT_MAX) exp_stall++;
            if (sz > 0 && out_ready) void'(exp_q.pop_front());
        end
    end

    // Model input side: record the beat the stage is expected to accept.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            #1;
            if (flush) begin
                if (exp_nonempty && exp_flush < CNT_MAX) exp_flush++;
                exp_q.delete();
            end else if (in_valid && exp_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic apply_reset();
        mon_en    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        exp_stall    = 0;
        exp_flush    = 0;
        prev_stalled = 1'b0;
        exp_ready    = 1'b1;
        exp_nonempty = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        apply_reset();
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_data",  {32'd0, out_data},  {32'd0, RV});

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure into FULL, then drain.
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_out_data", {32'd0, out_data}, 64'h11);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL with a beat offered.
        drive(1'b1, 32'hA1, 1'b0, 1'b0);
        drive(1'b1, 32'hA2, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_out_data",  {32'd0, out_data},  {32'd0, RV});
        check("flush_in_ready",  {63'd0, in_ready},  64'd1);
`ifdef PIPE_SKID_PERF_EN
        check("flush_cnt_one", {60'd0, flush_cnt}, 64'd1);
`else
        check("flush_cnt_off", {60'd0, flush_cnt}, 64'd0);
`endif
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom % 2), W'($urandom), 1'($urandom % 2), ($urandom % 64) == 0);
        end
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while FULL.
        apply_reset();
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        drive(1'b1, 32'h45, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready",  {63'd0, in_ready},  64'd1);
        check("arst_out_data",  {32'd0, out_data},  {32'd0, RV});
        check("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);

        // Long stall to saturate the stall counter.
        apply_reset();
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        repeat (21) drive(1'b0, '0, 1'b0, 1'b0);
        #1;
`ifdef PIPE_SKID_PERF_EN
        check("stall_sat", {60'd0, stall_cnt}, 64'(CNT_MAX));
`else
        check("stall_off", {60'd0, stall_cnt}, 64'd0);
`endif
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
